// File: rtl/bank_sched_pkg.sv
// Shared types and widths for the per-bank command scheduler.
package bank_sched_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned REFI_W = 16;

  typedef enum logic [4:0] {
    S_IDLE,
    S_OPEN,
    S_PRE,
    S_ACT,
    S_CAS,
    S_BURST,
    S_REF
  } sched_state_t;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PR,
    CMD_RD,
    CMD_WR,
    CMD_REF
  } cmd_t;

endpackage

// File: rtl/sched_wait_ctr.sv
// Loadable down-counter that holds at zero. Used for command spacing and
// for the refresh interval.
module sched_wait_ctr import bank_sched_pkg::*; #(
  parameter int unsigned      Width  = CNT_W,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] value,
  output logic             zero
);

  logic [Width-1:0] value_q;

  // Load wins; otherwise count down and saturate at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RstVal;
    end else if (load) begin
      value_q <= load_val;
    end else if (value_q != '0) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/bank_cmd_sched.sv
// Per-bank command scheduler: sequences PR/ACT/RD/WR/REF with timed spacing,
// tracks the open row and inserts periodic refresh.
// Define BANK_CLOSED_PAGE_EN to precharge after every burst (closed-page policy);
// by default the row is left open (open-page policy).
module bank_cmd_sched #(
  parameter int unsigned T_CL   = 17,
  parameter int unsigned T_RCD  = 17,
  parameter int unsigned T_RP   = 17,
  parameter int unsigned T_RFC  = 34,
  parameter int unsigned BL     = 8,
  parameter int unsigned T_REFI = 7800,
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned COL_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cmd_act,
  output logic             cmd_pr,
  output logic             cmd_rd,
  output logic             cmd_wr,
  output logic             cmd_ref,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic             burst_act,
  output logic             rsp_valid,
  output logic             row_open,
  output logic             ref_pending
);
  import bank_sched_pkg::*;

  localparam logic [CNT_W-1:0]  LdCl   = CNT_W'(T_CL - 1);
  localparam logic [CNT_W-1:0]  LdRcd  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0]  LdRp   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0]  LdRfc  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0]  LdBl   = CNT_W'(BL - 1);
  localparam logic [REFI_W-1:0] LdRefi = REFI_W'(T_REFI);

  sched_state_t     state_q, state_d;
  cmd_t             cmd_d, cas_cmd;
  logic             wait_ld, wait_zero, refi_zero, accept;
  logic [CNT_W-1:0] wait_ld_val, wait_ct;
  logic [REFI_W-1:0] refi_ct;
  logic             burst_d, rsp_d, req_pend_q, req_pend_d;
  logic             lat_rw_q;
  logic [ROW_W-1:0] lat_row_q, row_src;
  logic [COL_W-1:0] lat_col_q, col_src;

  sched_wait_ctr #(.Width(CNT_W), .RstVal('0)) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_ld),
    .load_val (wait_ld_val),
    .value    (wait_ct),
    .zero     (wait_zero)
  );

  sched_wait_ctr #(.Width(REFI_W), .RstVal(LdRefi)) u_refi_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_d == CMD_REF),
    .load_val (LdRefi),
    .value    (refi_ct),
    .zero     (refi_zero)
  );

  // Expiry in the current cycle already blocks acceptance so refresh wins the tie.
  assign req_ready = ((state_q == S_IDLE) || (state_q == S_OPEN)) && !ref_pending &&
                     (refi_ct != '0);
  assign accept    = req_valid && req_ready;
  assign row_src   = accept ? req_row : lat_row_q;
  assign col_src   = accept ? req_col : lat_col_q;
  assign cas_cmd   = (accept ? req_rw : lat_rw_q) ? CMD_WR : CMD_RD;

  // Next-state, command selection and wait-counter loads.
  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_NOP;
    wait_ld     = 1'b0;
    wait_ld_val = '0;
    burst_d     = 1'b0;
    rsp_d       = 1'b0;
    req_pend_d  = req_pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (ref_pending) begin
          cmd_d = CMD_REF; state_d = S_REF; wait_ld = 1'b1; wait_ld_val = LdRfc;
        end else if (accept) begin
          cmd_d = CMD_ACT; state_d = S_ACT; wait_ld = 1'b1; wait_ld_val = LdRcd;
          req_pend_d = 1'b1;
        end
      end
      S_OPEN: begin
        if (ref_pending) begin
          cmd_d = CMD_PR; state_d = S_PRE; wait_ld = 1'b1; wait_ld_val = LdRp;
        end else if (accept) begin
          req_pend_d = 1'b1;
          wait_ld    = 1'b1;
          if (req_row == cmd_row) begin
            cmd_d = cas_cmd; state_d = S_CAS; wait_ld_val = LdCl;
          end else begin
            cmd_d = CMD_PR; state_d = S_PRE; wait_ld_val = LdRp;
          end
        end
      end
      S_PRE: begin
        // A request in flight reopens its row; otherwise this precharge was for refresh
        // or closed-page cleanup.
        if (wait_zero) begin
          if (req_pend_q) begin
            cmd_d = CMD_ACT; state_d = S_ACT; wait_ld = 1'b1; wait_ld_val = LdRcd;
          end else if (ref_pending) begin
            cmd_d = CMD_REF; state_d = S_REF; wait_ld = 1'b1; wait_ld_val = LdRfc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ACT: begin
        if (wait_zero) begin
          cmd_d = cas_cmd; state_d = S_CAS; wait_ld = 1'b1; wait_ld_val = LdCl;
        end
      end
      S_CAS: begin
        if (wait_zero) begin
          state_d = S_BURST; wait_ld = 1'b1; wait_ld_val = LdBl;
          burst_d = 1'b1;
          rsp_d   = (BL == 1);
        end
      end
      S_BURST: begin
        if (wait_zero) begin
          req_pend_d = 1'b0;
`ifdef BANK_CLOSED_PAGE_EN
          cmd_d = CMD_PR; state_d = S_PRE; wait_ld = 1'b1; wait_ld_val = LdRp;
`else
          state_d = S_OPEN;
`endif
        end else begin
          burst_d = 1'b1;
          rsp_d   = (wait_ct == CNT_W'(1));
        end
      end
      S_REF: begin
        if (wait_zero) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered command pulses, address holding and refresh bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_pend_q  <= 1'b0;
      cmd_act     <= 1'b0;
      cmd_pr      <= 1'b0;
      cmd_rd      <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_ref     <= 1'b0;
      cmd_row     <= '0;
      cmd_col     <= '0;
      burst_act   <= 1'b0;
      rsp_valid   <= 1'b0;
      row_open    <= 1'b0;
      ref_pending <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_pend_q  <= req_pend_d;
      cmd_act     <= (cmd_d == CMD_ACT);
      cmd_pr      <= (cmd_d == CMD_PR);
      cmd_rd      <= (cmd_d == CMD_RD);
      cmd_wr      <= (cmd_d == CMD_WR);
      cmd_ref     <= (cmd_d == CMD_REF);
      burst_act   <= burst_d;
      rsp_valid   <= rsp_d;
      ref_pending <= (ref_pending | refi_zero) & (cmd_d != CMD_REF);
      if (cmd_d == CMD_ACT) begin
        cmd_row  <= row_src;
        row_open <= 1'b1;
      end else if (cmd_d == CMD_PR) begin
        row_open <= 1'b0;
      end
      if ((cmd_d == CMD_RD) || (cmd_d == CMD_WR)) begin
        cmd_col <= col_src;
      end
      if (accept) begin
        lat_rw_q  <= req_rw;
        lat_row_q <= req_row;
        lat_col_q <= req_col;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_sched.sv
// Scoreboard bench for bank_cmd_sched with short timings. Honours BANK_CLOSED_PAGE_EN.
module tb_bank_cmd_sched;

  localparam int TCL = 2, TRCD = 3, TRP = 2, TRFC = 5, TBL = 4, TREFI = 100;
  localparam int K_ACT = 1, K_PR = 2, K_RD = 3, K_WR = 4, K_REF = 5, K_RSP = 6;
`ifdef BANK_CLOSED_PAGE_EN
  localparam bit CLOSED = 1'b1;
`else
  localparam bit CLOSED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready, cmd_act, cmd_pr, cmd_rd, cmd_wr, cmd_ref;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        burst_act, rsp_valid, row_open, ref_pending;

  bank_cmd_sched #(
    .T_CL(TCL), .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC), .BL(TBL), .T_REFI(TREFI),
    .ROW_W(16), .COL_W(10)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_row(req_row), .req_col(req_col), .cmd_act(cmd_act), .cmd_pr(cmd_pr),
    .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_ref(cmd_ref), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .burst_act(burst_act), .rsp_valid(rsp_valid), .row_open(row_open),
    .ref_pending(ref_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int addr;
  } ev_t;
  ev_t sb[$];

  int   n_chk = 0, n_err = 0;
  int   burst_run = 0;
  logic rsp_prev = 1'b0;
  logic m_open = 1'b0;
  int   m_row = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_ACT:   return "act";
      K_PR:    return "pr";
      K_RD:    return "rd";
      K_WR:    return "wr";
      K_REF:   return "ref";
      default: return "rsp";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int c, input int addr);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int addr_obs);
    ev_t e;
    if (sb.size() == 0) begin
      chk({"unexpected_", kname(kind)}, kind, 0);
    end else begin
      e = sb.pop_front();
      chk({kname(e.kind), "_kind"}, kind, e.kind);
      chk({kname(e.kind), "_cycle"}, cyc, e.cyc);
      if (e.addr >= 0) chk({kname(e.kind), "_addr"}, addr_obs, e.addr);
    end
  endtask

  // Expected command/response sequence for one accepted request.
  task automatic exp_req(input logic rw, input int row, input int col, input int a,
                         output int rsp);
    int cas;
    if (CLOSED || !m_open) begin
      push_ev(K_ACT, a + 1, row);
      cas = a + 1 + TRCD;
    end else if (m_row == row) begin
      cas = a + 1;
    end else begin
      push_ev(K_PR, a + 1, -1);
      push_ev(K_ACT, a + 1 + TRP, row);
      cas = a + 1 + TRP + TRCD;
    end
    push_ev(rw ? K_WR : K_RD, cas, col);
    rsp = cas + TCL + TBL - 1;
    push_ev(K_RSP, rsp, -1);
    if (CLOSED) begin
      push_ev(K_PR, rsp + 1, -1);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
      m_row  = row;
    end
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) chk("schedule_slip", cyc, c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive_req(input logic rw, input int row, input int col, input int start,
                           input int exp_acc);
    int guard;
    wait_cyc(start);
    req_valid = 1'b1;
    req_rw    = rw;
    req_row   = 16'(row);
    req_col   = 10'(col);
    guard     = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready", req_ready, 1);
    chk("accept_cycle", cyc, exp_acc);
  endtask

  task automatic do_req(input logic rw, input int row, input int col, input int start,
                        input int exp_acc, output int rsp);
    drive_req(rw, row, col, start, exp_acc);
    exp_req(rw, row, col, exp_acc, rsp);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Output monitor: every pulse is matched against the scoreboard head.
  always @(negedge clk) begin : mon
    automatic int ncmd    = $countones({cmd_act, cmd_pr, cmd_rd, cmd_wr, cmd_ref});
    automatic int run_now = burst_act ? burst_run + 1 : 0;
    if (!rst) begin
      if (ncmd > 1) chk("cmd_onehot", ncmd, 1);
      if (cmd_act)     pop_cmp(K_ACT, int'(cmd_row));
      else if (cmd_pr) pop_cmp(K_PR, 0);
      else if (cmd_rd) pop_cmp(K_RD, int'(cmd_col));
      else if (cmd_wr) pop_cmp(K_WR, int'(cmd_col));
      else if (cmd_ref) pop_cmp(K_REF, 0);
      if (rsp_valid) begin
        pop_cmp(K_RSP, 0);
        chk("burst_len", run_now, TBL);
      end
      if (rsp_prev) chk("burst_end", burst_act, 0);
    end
    burst_run <= run_now;
    rsp_prev  <= rsp_valid & ~rst;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, ref_c, act_c, acc6;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_row_open", row_open, 0);
    chk("rst_ref_pending", ref_pending, 0);
    chk("rst_cmd_row", cmd_row, 0);
    chk("rst_cmd_col", cmd_col, 0);
    chk("rst_burst_act", burst_act, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmds", $countones({cmd_act, cmd_pr, cmd_rd, cmd_wr, cmd_ref}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Empty bank, row hit (ACT path when closed-page), row miss.
    do_req(1'b0, 5, 9, 10, 10, r);
    do_req(1'b1, 5, 3, 20, CLOSED ? 22 : 20, r);
    do_req(1'b0, 7, 4, 36, 36, r);

    // Refresh interval expires at cycle 102 while a request is in flight.
    do_req(1'b1, 7, 1, 99, 99, r);
    if (!CLOSED) begin
      push_ev(K_PR, r + 2, -1);
      ref_c = r + 2 + TRP;
    end else begin
      ref_c = r + 1 + TRP;
    end
    push_ev(K_REF, ref_c, -1);
    m_open = 1'b0;
    wait_cyc(104);
    chk("ref_pending_mid_req", ref_pending, 1);
    wait_cyc(ref_c + TRFC - 1);
    chk("ready_during_ref", req_ready, 0);
    wait_cyc(ref_c + TRFC);
    chk("ready_after_ref", req_ready, 1);
    chk("row_open_after_ref", row_open, 0);

    // Expiry coincides with a request in S_IDLE: refresh goes first.
    push_ev(K_REF, ref_c + TREFI + 2, -1);
    do_req(1'b0, 9, 2, ref_c + TREFI, ref_c + TREFI + 2 + TRFC, r);

    // Reset while waiting in S_ACT, then replay the same request.
    drive_req(1'b0, 11, 6, ref_c + 125, ref_c + 125);
    if (m_open) begin
      push_ev(K_PR, ref_c + 126, -1);
      act_c = ref_c + 126 + TRP;
    end else begin
      act_c = ref_c + 126;
    end
    push_ev(K_ACT, act_c, 11);
    @(negedge clk);
    req_valid = 1'b0;
    wait_cyc(act_c + 1);
    rst = 1'b1;
    #1;
    chk("arst_row_open", row_open, 0);
    chk("arst_cmd_row", cmd_row, 0);
    chk("arst_cmd_col", cmd_col, 0);
    chk("arst_burst_act", burst_act, 0);
    chk("arst_cmds", $countones({cmd_act, cmd_pr, cmd_rd, cmd_wr, cmd_ref}), 0);
    m_open = 1'b0;
    wait_cyc(act_c + 3);
    rst  = 1'b0;
    acc6 = act_c + 3;
    do_req(1'b0, 11, 6, acc6, acc6, r);

    wait_cyc(r + 8);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
